arrow_field: RTL

//  Multi-lane, multi-arrow sprite engine for the rhythm game.
//  - Keeps a pool of NUM_SLOTS moving arrows, each in one of NUM_LANES lanes.
//  - Moves every active arrow once per video frame; retires arrows that are hit or leave the screen.
//  - Grades player hits against a target line; renders arrow pixels for the current hcount/vcount.
//  - Sits between the chart sequencer (spawns) and the pixel mixer (pixel_out/valid_out).

---
 rtl/arrow_pkg.sv | 33 +++
 rtl/arrow_field_if.sv | 36 +++
 rtl/arrow_slot.sv | 80 ++++++++
 rtl/arrow_field.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/arrow_pkg.sv
`default_nettype none
// ============================================================================
// Module   : arrow_pkg
// Brief    : Shared types and constants for the arrow_field sprite engine.
// Revision : 1.0 - initial release
// ============================================================================
package arrow_pkg;

   typedef enum logic [1:0] {
      MISS    = 2'd0,
      GOOD    = 2'd1,
      PERFECT = 2'd2
   } hit_grade_t;

   localparam int SCREEN_W = 1280;
   localparam int SCREEN_H = 720;

   localparam logic [0:7][11:0] LANE_COLOR = {
      12'hF00, 12'h0F0, 12'h00F, 12'hFF0,
      12'hF0F, 12'h0FF, 12'hF80, 12'h8F0
   };

   // Lane is stored 3 bits wide so the colour table covers every lane.
   typedef struct packed {
      logic               active;
      logic               up;
      logic [2:0]         speed;
      logic [2:0]         lane;
      logic signed [11:0] y;
   } arrow_slot_t;

endpackage
`default_nettype wire

// File: rtl/arrow_field_if.sv
`default_nettype none
// ============================================================================
// Module   : arrow_field_if
// Brief    : Spawn handshake plus hit/grade/miss event bus of arrow_field.
// Revision : 1.0 - initial release
// ============================================================================
interface arrow_field_if
   import arrow_pkg::*;
#(
   parameter int LW = 2
);
   logic          spawn_valid_in;
   logic          spawn_ready_out;
   logic [LW-1:0] spawn_lane_in;
   logic [2:0]    spawn_speed_in;
   logic          spawn_up_in;
   logic          hit_valid_in;
   logic [LW-1:0] hit_lane_in;
   logic          grade_valid_out;
   hit_grade_t    grade_out;
   logic          miss_valid_out;
   logic [LW-1:0] miss_lane_out;

   modport master (
      output spawn_valid_in, spawn_lane_in, spawn_speed_in, spawn_up_in,
      output hit_valid_in, hit_lane_in,
      input  spawn_ready_out, grade_valid_out, grade_out, miss_valid_out, miss_lane_out
   );

   modport slave (
      input  spawn_valid_in, spawn_lane_in, spawn_speed_in, spawn_up_in,
      input  hit_valid_in, hit_lane_in,
      output spawn_ready_out, grade_valid_out, grade_out, miss_valid_out, miss_lane_out
   );
endinterface
`default_nettype wire

// File: rtl/arrow_slot.sv
`default_nettype none
// ============================================================================
// Module   : arrow_slot
// Brief    : One arrow: registers, per-frame move/retire, coverage and distance.
// Revision : 1.0 - initial release
// ============================================================================
module arrow_slot
   import arrow_pkg::*;
#(
   parameter int WIDTH      = 8,
   parameter int HEIGHT     = 32,
   parameter int LANE_X0    = 448,
   parameter int LANE_PITCH = 64,
   parameter int SPEED_UNIT = 4,
   parameter int HIT_Y      = 600
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        i_tick,
   input  logic        i_load,
   input  logic        i_free,
   input  logic [2:0]  i_lane,
   input  logic [2:0]  i_speed,
   input  logic        i_up,
   input  logic [10:0] i_hcount,
   input  logic [9:0]  i_vcount,
   output logic        o_active,
   output logic [2:0]  o_lane,
   output logic [11:0] o_dist,
   output logic        o_cover,
   output logic        o_retire
);
   localparam logic signed [12:0] c_y_top   = 13'(-HEIGHT);
   localparam logic signed [12:0] c_y_bot   = 13'(SCREEN_H);
   localparam logic signed [12:0] c_ty_dn   = 13'(HIT_Y);
   localparam logic signed [12:0] c_ty_up   = 13'(SCREEN_H - HIT_Y - HEIGHT);
   localparam logic signed [11:0] c_y_spawn = 12'(SCREEN_H - HEIGHT);

   arrow_slot_t        r_slot;
   logic signed [12:0] w_y, w_step, w_y_next, w_diff, w_vpos;
   logic [11:0]        w_x0, w_hpos;
   logic               w_off;

   assign w_y      = {r_slot.y[11], r_slot.y};
   assign w_step   = 13'(r_slot.speed) * 13'(SPEED_UNIT);
   assign w_y_next = r_slot.up ? (w_y - w_step) : (w_y + w_step);
   assign w_off    = r_slot.up ? (w_y_next <= c_y_top) : (w_y_next >= c_y_bot);
   assign w_diff   = w_y - (r_slot.up ? c_ty_up : c_ty_dn);
   assign o_dist   = w_diff[12] ? 12'(-w_diff) : w_diff[11:0];

   assign w_x0     = 12'(LANE_X0) + 12'(r_slot.lane) * 12'(LANE_PITCH);
   assign w_hpos   = {1'b0, i_hcount};
   assign w_vpos   = {3'b000, i_vcount};
   assign o_cover  = r_slot.active
                     && (w_hpos >= w_x0) && (w_hpos <= w_x0 + 12'(WIDTH - 1))
                     && (w_vpos >= w_y)  && (w_vpos <= w_y + 13'(HEIGHT - 1));

   // A slot taken by a hit this cycle neither moves nor reports a miss.
   assign o_retire = r_slot.active && i_tick && !i_free && w_off;
   assign o_active = r_slot.active;
   assign o_lane   = r_slot.lane;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_slot <= '0;
      end else if (i_free) begin
         r_slot.active <= 1'b0;
      end else if (i_load) begin
         r_slot.active <= 1'b1;
         r_slot.lane   <= i_lane;
         r_slot.speed  <= i_speed;
         r_slot.up     <= i_up;
         r_slot.y      <= i_up ? c_y_spawn : 12'sd0;
      end else if (i_tick && r_slot.active) begin
         r_slot.y <= w_y_next[11:0];
         if (w_off) r_slot.active <= 1'b0;
      end
   end
endmodule
`default_nettype wire

// File: rtl/arrow_field.sv
`default_nettype none
// ============================================================================
// Module   : arrow_field
// Brief    : Multi-lane arrow pool: spawn allocation, hit grading, miss queue, render.
// Revision : 1.0 - initial release
// ============================================================================
module arrow_field
   import arrow_pkg::*;
#(
   parameter int NUM_LANES   = 4,
   parameter int NUM_SLOTS   = 16,
   parameter int WIDTH       = 8,
   parameter int HEIGHT      = 32,
   parameter int LANE_X0     = 448,
   parameter int LANE_PITCH  = 64,
   parameter int SPEED_UNIT  = 4,
   parameter int HIT_Y       = 600,
   parameter int HIT_WIN     = 16,
   parameter int PERFECT_WIN = 4
) (
   input  logic                       clk,
   input  logic                       rst_n_in,
   input  logic [10:0]                hcount_in,
   input  logic [9:0]                 vcount_in,
   arrow_field_if.slave               bus,
   output logic [$clog2(NUM_SLOTS):0] active_cnt_out,
   output logic [11:0]                pixel_out,
   output logic                       valid_out
);
   localparam int LW = $clog2(NUM_LANES);
   localparam int SW = $clog2(NUM_SLOTS);
   localparam int CW = SW + 1;

   logic [NUM_SLOTS-1:0] w_active, w_cover, w_retire, w_load, w_free, w_pend_all;
   logic [2:0]           w_lane [NUM_SLOTS];
   logic [11:0]          w_dist [NUM_SLOTS];
   logic [SW-1:0]        w_free_idx, w_hit_idx, w_miss_idx, w_pix_idx;
   logic                 w_origin, w_tick, w_spawn_fire, w_hit_found, w_miss_any, w_pix_any;
   logic [11:0]          w_best_d, w_color;
   logic [2:0]           w_miss_lane;

   logic                 r_origin_d, r_alive, r_grade_valid, r_miss_valid, r_valid;
   hit_grade_t           r_grade;
   logic [LW-1:0]        r_miss_lane;
   logic [NUM_SLOTS-1:0] r_pend;
   logic [2:0]           r_pend_lane [NUM_SLOTS];
   logic [CW-1:0]        r_cnt;
   logic [11:0]          r_pixel;

   assign w_origin     = (hcount_in == 11'd0) && (vcount_in == 10'd0);
   assign w_tick       = w_origin && !r_origin_d;
   assign w_spawn_fire = bus.spawn_valid_in && bus.spawn_ready_out;

   for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_slot
      arrow_slot #(
         .WIDTH(WIDTH), .HEIGHT(HEIGHT), .LANE_X0(LANE_X0), .LANE_PITCH(LANE_PITCH),
         .SPEED_UNIT(SPEED_UNIT), .HIT_Y(HIT_Y)
      ) u_slot (
         .clk(clk), .rst_n(rst_n_in), .i_tick(w_tick), .i_load(w_load[i]), .i_free(w_free[i]),
         .i_lane(3'(bus.spawn_lane_in)), .i_speed(bus.spawn_speed_in), .i_up(bus.spawn_up_in),
         .i_hcount(hcount_in), .i_vcount(vcount_in), .o_active(w_active[i]), .o_lane(w_lane[i]),
         .o_dist(w_dist[i]), .o_cover(w_cover[i]), .o_retire(w_retire[i])
      );
      assign w_load[i] = w_spawn_fire && (w_free_idx == SW'(i));
      assign w_free[i] = bus.hit_valid_in && w_hit_found && (w_hit_idx == SW'(i));
   end

   // Priority encoders: downward scans so the lowest index is the final winner.
   always_comb begin
      w_free_idx = '0;
      w_miss_idx = '0;
      w_pix_idx  = '0;
      for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
         if (!w_active[i])  w_free_idx = SW'(i);
         if (w_pend_all[i]) w_miss_idx = SW'(i);
         if (w_cover[i])    w_pix_idx  = SW'(i);
      end
   end

   // Strict '<' keeps the earlier (lower) index on equal distances.
   always_comb begin
      w_hit_found = 1'b0;
      w_hit_idx   = '0;
      w_best_d    = '1;
      for (int i = 0; i < NUM_SLOTS; i++) begin
         if (w_active[i] && (w_lane[i] == 3'(bus.hit_lane_in)) && (w_dist[i] <= 12'(HIT_WIN))
             && (!w_hit_found || (w_dist[i] < w_best_d))) begin
            w_hit_found = 1'b1;
            w_hit_idx   = SW'(i);
            w_best_d    = w_dist[i];
         end
      end
   end

   assign w_pend_all  = r_pend | w_retire;
   assign w_miss_any  = |w_pend_all;
   assign w_miss_lane = w_retire[w_miss_idx] ? w_lane[w_miss_idx] : r_pend_lane[w_miss_idx];
   assign w_pix_any   = |w_cover;
   assign w_color     = LANE_COLOR[w_lane[w_pix_idx]]
                        | ((w_dist[w_pix_idx] <= 12'(HIT_WIN)) ? 12'h111 : 12'h000);

   always_ff @(posedge clk or negedge rst_n_in) begin
      if (!rst_n_in) begin
         r_origin_d    <= 1'b0;
         r_alive       <= 1'b0;
         r_grade_valid <= 1'b0;
         r_grade       <= MISS;
         r_miss_valid  <= 1'b0;
         r_miss_lane   <= '0;
         r_pend        <= '0;
         r_cnt         <= '0;
         r_valid       <= 1'b0;
         r_pixel       <= '0;
         for (int i = 0; i < NUM_SLOTS; i++) r_pend_lane[i] <= '0;
      end else begin
         r_origin_d    <= w_origin;
         r_alive       <= 1'b1;
         r_grade_valid <= bus.hit_valid_in;
         r_grade       <= !(bus.hit_valid_in && w_hit_found) ? MISS
                          : ((w_best_d <= 12'(PERFECT_WIN)) ? PERFECT : GOOD);
         r_miss_valid  <= w_miss_any;
         r_miss_lane   <= w_miss_any ? LW'(w_miss_lane) : '0;
         r_pend        <= w_pend_all & ~(w_miss_any ? (NUM_SLOTS'(1) << w_miss_idx) : '0);
         for (int i = 0; i < NUM_SLOTS; i++)
            if (w_retire[i]) r_pend_lane[i] <= w_lane[i];
         r_cnt         <= CW'($countones(w_active));
         r_valid       <= w_pix_any;
         r_pixel       <= w_pix_any ? w_color : 12'h000;
      end
   end

   assign bus.spawn_ready_out = r_alive && !(&w_active);
   assign bus.grade_valid_out = r_grade_valid;
   assign bus.grade_out       = r_grade;
   assign bus.miss_valid_out  = r_miss_valid;
   assign bus.miss_lane_out   = r_miss_lane;
   assign active_cnt_out      = r_cnt;
   assign pixel_out           = r_pixel;
   assign valid_out           = r_valid;
endmodule
`default_nettype wire
